// File: rtl/vga_timing_gen_pkg.sv
// Shared timing presets and helpers for the VGA raster generator.
// Preset PLL values assume a 12 MHz reference into an iCE40 PLL with DIVR=0.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned res_h;
    int unsigned fp_h;
    int unsigned sync_h;
    int unsigned bp_h;
    bit          neg_h;
    int unsigned res_v;
    int unsigned fp_v;
    int unsigned sync_v;
    int unsigned bp_v;
    bit          neg_v;
    int unsigned divf;
    int unsigned divq;
  } vga_preset_t;

  localparam vga_preset_t PRESET_640X480 = '{
    res_h: 640, fp_h: 16, sync_h: 96, bp_h: 48, neg_h: 1'b1,
    res_v: 480, fp_v: 10, sync_v: 2, bp_v: 33, neg_v: 1'b1,
    divf: 66, divq: 5
  };

  localparam vga_preset_t PRESET_720X400 = '{
    res_h: 720, fp_h: 15, sync_h: 108, bp_h: 51, neg_h: 1'b1,
    res_v: 400, fp_v: 12, sync_v: 2, bp_v: 35, neg_v: 1'b0,
    divf: 74, divq: 5
  };

  localparam vga_preset_t PRESET_720X480 = '{
    res_h: 720, fp_h: 16, sync_h: 62, bp_h: 60, neg_h: 1'b1,
    res_v: 480, fp_v: 9, sync_v: 6, bp_v: 30, neg_v: 1'b1,
    divf: 71, divq: 5
  };

  function automatic int total(input int res, input int fp, input int sync, input int bp);
    return res + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle plus the core-side raster interrupt controls.
interface vga_timing_gen_if #(
  parameter int CW = 12
);
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          hs;
  logic          vs;
  logic          de;
  logic          line_start;
  logic          frame_start;
  logic          vblank;
  logic          irq_line_wr;
  logic [CW-1:0] irq_line_d;
  logic          irq_ack;
  logic          irq;

  modport master (
    output x, y, hs, vs, de, line_start, frame_start, vblank, irq,
    input  irq_line_wr, irq_line_d, irq_ack
  );

  modport slave (
    input  x, y, hs, vs, de, line_start, frame_start, vblank, irq,
    output irq_line_wr, irq_line_d, irq_ack
  );
endinterface

// File: rtl/vga_sync_delay.sv
// PIPE-deep shift register that delays {hs, vs, de} to match downstream BRAM latency.
// Shifts only on enabled cycles so it stays aligned with the raster counters.
module vga_sync_delay #(
  parameter int PIPE  = 2,
  parameter bit NEG_H = 1'b1,
  parameter bit NEG_V = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [2:0] d,
  output logic [2:0] q
);

  localparam logic [2:0] IDLE = {NEG_H, NEG_V, 1'b0};

  logic [2:0] stage [PIPE];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE; i++) begin
        stage[i] <= IDLE;
      end
    end else if (enable) begin
      stage[0] <= d;
      for (int i = 1; i < PIPE; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[PIPE-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with delayed sync/enable outputs.
// Optional raster-line interrupt is built when VGA_TIMING_RASTER_IRQ_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int RES_H  = 640,
  parameter int FP_H   = 16,
  parameter int SYNC_H = 96,
  parameter int BP_H   = 48,
  parameter bit NEG_H  = 1'b1,
  parameter int RES_V  = 480,
  parameter int FP_V   = 10,
  parameter int SYNC_V = 2,
  parameter int BP_V   = 33,
  parameter bit NEG_V  = 1'b1,
  parameter int CW     = 12,
  parameter int PIPE   = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  vga_timing_gen_if.master   bus
);

  localparam int TOTAL_H = total(RES_H, FP_H, SYNC_H, BP_H);
  localparam int TOTAL_V = total(RES_V, FP_V, SYNC_V, BP_V);

  localparam logic [CW-1:0] H_LAST   = CW'(TOTAL_H - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(TOTAL_V - 1);
  localparam logic [CW-1:0] H_RES    = CW'(RES_H);
  localparam logic [CW-1:0] V_RES    = CW'(RES_V);
  localparam logic [CW-1:0] HS_BEGIN = CW'(RES_H + FP_H);
  localparam logic [CW-1:0] HS_END   = CW'(RES_H + FP_H + SYNC_H);
  localparam logic [CW-1:0] VS_BEGIN = CW'(RES_V + FP_V);
  localparam logic [CW-1:0] VS_END   = CW'(RES_V + FP_V + SYNC_V);

  logic [CW-1:0] x_q;
  logic [CW-1:0] y_q;
  logic [CW-1:0] x_next;
  logic [CW-1:0] y_next;
  logic          vblank_q;
  logic          line_start_c;
  logic          frame_start_c;
  logic [2:0]    sync_raw;
  logic [2:0]    sync_dly;

  always_comb begin
    x_next = x_q + 1'b1;
    y_next = y_q;
    if (x_q == H_LAST) begin
      x_next = '0;
      y_next = (y_q == V_LAST) ? '0 : y_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q      <= '0;
      y_q      <= '0;
      vblank_q <= 1'b0;
    end else if (enable) begin
      x_q      <= x_next;
      y_q      <= y_next;
      vblank_q <= (y_next >= V_RES);
    end
  end

  // Pulses mark the enabled cycle that consumes position x==0, so a stall never repeats them.
  assign line_start_c  = reset_n & enable & (x_q == '0);
  assign frame_start_c = line_start_c & (y_q == '0);

  assign sync_raw[2] = ((x_q >= HS_BEGIN) && (x_q < HS_END)) ^ NEG_H;
  assign sync_raw[1] = ((y_q >= VS_BEGIN) && (y_q < VS_END)) ^ NEG_V;
  assign sync_raw[0] = (x_q < H_RES) && (y_q < V_RES);

  vga_sync_delay #(
    .PIPE  (PIPE),
    .NEG_H (NEG_H),
    .NEG_V (NEG_V)
  ) u_sync_delay (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .d       (sync_raw),
    .q       (sync_dly)
  );

  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.vblank      = vblank_q;
  assign bus.line_start  = line_start_c;
  assign bus.frame_start = frame_start_c;
  assign bus.hs          = sync_dly[2];
  assign bus.vs          = sync_dly[1];
  assign bus.de          = sync_dly[0];

`ifdef VGA_TIMING_RASTER_IRQ_EN
  logic [CW-1:0] irq_cmp;
  logic          irq_q;

  // Compare only at line_start, so a write lands on the next line boundary; set beats ack.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_cmp <= '1;
      irq_q   <= 1'b0;
    end else begin
      if (bus.irq_line_wr) begin
        irq_cmp <= bus.irq_line_d;
      end
      if (line_start_c && (y_q == irq_cmp)) begin
        irq_q <= 1'b1;
      end else if (bus.irq_ack) begin
        irq_q <= 1'b0;
      end
    end
  end

  assign bus.irq = irq_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{bus.irq_line_wr, bus.irq_line_d, bus.irq_ack};
  assign bus.irq = 1'b0;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for the VGA blinkenlights front panel. It replaces the fixed, macro-selected 640x480/720x400/720x480 constants with module parameters. It produces pixel coordinates for character/font address generation and sync/enable outputs delayed to match downstream BRAM latency. It can also raise an optional raster-line interrupt toward the rj32 core.

## Interface
Parameters:
- `RES_H`, 640: active pixels per line
- `FP_H`, 16: horizontal front porch, in pixels
- `SYNC_H`, 96: horizontal sync width
- `BP_H`, 48: horizontal back porch
- `NEG_H`, 1: 1 = hs active-low
- `RES_V`, 480: active lines
- `FP_V`, 10: vertical front porch, in lines
- `SYNC_V`, 2: vertical sync width
- `BP_V`, 33: vertical back porch
- `NEG_V`, 1: 1 = vs active-low
- `CW`, 12: counter width; must satisfy 2^CW > all totals
- `PIPE`, 2: delay from `x`/`y` to `hs`/`vs`/`de`, in enabled cycles; range 1..8

Ports:
- `clock` in 1: pixel clock
- `reset_n` in 1: asynchronous, active-low reset
- `enable` in 1: pixel clock enable; when low, all state holds
- `x` out CW: current horizontal count
- `y` out CW: current vertical count
- `hs` out 1: horizontal sync, delayed by PIPE, polarity set by NEG_H
- `vs` out 1: vertical sync, delayed by PIPE, polarity set by NEG_V
- `de` out 1: display enable, delayed by PIPE
- `line_start` out 1: one-cycle pulse, undelayed, when `x`==0
- `frame_start` out 1: one-cycle pulse, undelayed, when `x`==0 and `y`==0
- `vblank` out 1: undelayed; high when `y` >= RES_V
- `irq_line_wr` in 1: load the compare line register
- `irq_line_d` in CW: compare line value
- `irq_ack` in 1: clear `irq`
- `irq` out 1: raster interrupt, level output

## Operation
Counters:
- TOTAL_H = RES_H+FP_H+SYNC_H+BP_H; TOTAL_V is defined the same way.
- On each `enable` cycle, `x` increments. At TOTAL_H-1, `x` wraps to 0 and `y` increments.
- `y` wraps to 0 after TOTAL_V-1. Both counters are unsigned CW bits.

Region order within a line is active, front porch, sync, back porch:
- hs is asserted for `x` in [RES_H+FP_H, RES_H+FP_H+SYNC_H).
- vs is asserted for `y` in [RES_V+FP_V, RES_V+FP_V+SYNC_V).
- de is high for `x`<RES_H and `y`<RES_V.

Pulses:
- `line_start` and `frame_start` are high only in cycles where `enable` is high and the stated condition holds.
- If `enable` is low, both pulses are 0.

Reset values:
- `x`=0, `y`=0.
- `hs`=NEG_H, `vs`=NEG_V (i.e. inactive), `de`=0.
- `line_start`=0, `frame_start`=0, `vblank`=0, `irq`=0.
- The entire delay pipeline is flushed to these inactive values.

Reset behaviour:
- Reset asserted mid-frame returns all outputs to reset values immediately.
- After release, the first enabled cycle presents `x`=0, `y`=0 with `frame_start`=1.

## Timing
- `x`, `y`, `vblank`, `line_start` and `frame_start` are registered. They all describe the same raster position.
- `hs`, `vs` and `de` for position (x,y) appear exactly PIPE enabled cycles later.
- The delay pipeline shifts only when `enable`=1.
- A stalled `enable` freezes the counters and the pipeline together, so alignment is never lost.
- Per frame: `de` is high for exactly RES_H×RES_V enabled cycles; `hs` has SYNC_H-cycle pulses; `vs` spans SYNC_V×TOTAL_H cycles.

## Configuration
Macro: `VGA_TIMING_RASTER_IRQ_EN`.

Defined:
- A CW-bit compare register, reset value all-ones, is loaded from `irq_line_d` on `irq_line_wr`.
- `irq` sets on the cycle after `line_start` when `y` equals the compare register.
- `irq` stays high until `irq_ack`.
- If set and `irq_ack` occur in the same cycle, set wins.
- A write to the compare register takes effect from the next `line_start`.

Not defined:
- The ports remain present, so top-level wiring is unchanged.
- `irq` is tied to 0; `irq_line_wr`, `irq_line_d` and `irq_ack` are ignored.
- No compare register is synthesised.

## Structure
Package `vga_timing_pkg`:
- Preset constant sets for 640x480, 720x400 and 720x480: all 10 timing values plus the PLL `divf`/`divq` for each.
- A `TOTAL` helper function.

Sub-module `vga_sync_delay`:
- Parametrised PIPE-deep, 3-bit shift register with a clock enable.
- Reset value is {NEG_H, NEG_V, 0}.

## Test plan
All scenarios use small parameters: RES_H=4, FP_H=1, SYNC_H=2, BP_H=1 (TOTAL_H=8); RES_V=3, FP_V=1, SYNC_V=1, BP_V=1 (TOTAL_V=6); NEG_H=1, NEG_V=0; PIPE=2.

1. Reset check: assert `reset_n`=0 mid-frame → `x`=`y`=0, `hs`=1, `vs`=0, `de`=0, `irq`=0. Release → first enabled cycle has `frame_start`=1.
2. Line check: run one line → `de` high for 4 cycles, starting 2 cycles after `x`=0. `hs` is low for delayed `x`=5..6. `line_start` pulses every 8 cycles.
3. Frame check: run 48 cycles →
   - `frame_start` pulses at cycles 0 and 48.
   - `vs` is high for delayed `y`=4 (8 cycles).
   - `vblank` is high for `y`=3..5.
   - `de` total = 12.
4. Enable stall: hold `enable`=0 for 5 cycles during `x`=2 → all outputs frozen, no pulses. The `de`/`x` offset stays at 2 enabled cycles.
5. IRQ (macro defined): write line 2 → `irq` rises the cycle after `line_start` at `y`=2. `irq_ack` clears it. Ack coincident with the next frame's set leaves `irq`=1.
6. IRQ (macro undefined): same stimulus as scenario 5 → `irq` stays 0 throughout.
